// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration controller for the divide/square-root unit.
// Accepts a start request in Execute, latches the iteration count and steps
// the digit-recurrence datapath through exactly that many cycles, then holds
// a done indication while Memory is stalled. Flush aborts from any state.
//
// Handshake: FDivStartE acts as "valid" and is held by the requester; the
// controller is "ready" only in IDLE with no flush. IFDivStartE is the
// transfer pulse (valid & ready). CyclesE and SpecialCaseE are sampled only
// in that cycle. FDivDoneE is a one-cycle result-valid, stretched while
// StallM is high.
module fdivsqrt_iter_ctrl #(
    parameter int DURLEN = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FDivStartE,
    input  logic [DURLEN-1:0] CyclesE,
    input  logic              SpecialCaseE,
    input  logic              StallM,
    input  logic              FlushE,
    output logic              IFDivStartE,
    output logic              IterEn,
    output logic              FDivBusyE,
    output logic              FDivDoneE,
    output logic [DURLEN-1:0] StepCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Current controller state; kept as a plainly named signal so checkers
    // can bind to it directly.
    state_t            state;
    logic [DURLEN-1:0] step_q;
    logic              iter_q;
    logic              done_q;
    logic              accept;
    logic              zero_iter;

    // Accept gated by reset so the pulse is low while reset is asserted,
    // even though the asynchronously reset state already reads IDLE.
    assign accept    = reset & (state == IDLE) & FDivStartE & ~FlushE;
    assign zero_iter = SpecialCaseE | (CyclesE == '0);

    // Main FSM: flush has priority over accept, iteration and stall. The
    // iter/done flags are registered alongside the state and always equal
    // its BUSY/DONE decode, so they never depend on same-cycle inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            step_q <= '0;
            iter_q <= 1'b0;
            done_q <= 1'b0;
        end else if (FlushE) begin
            state  <= IDLE;
            step_q <= '0;
            iter_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (zero_iter) begin
                            state  <= DONE;
                            step_q <= '0;
                            iter_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= BUSY;
                            step_q <= CyclesE;
                            iter_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    // A count of 1 is the last step; 0 is never decremented,
                    // so the counter cannot wrap.
                    if (step_q == DURLEN'(1)) begin
                        state  <= DONE;
                        step_q <= '0;
                        iter_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        step_q <= step_q - DURLEN'(1);
                    end
                end
                DONE: begin
                    // No re-accept from DONE; a held request is taken in
                    // the following IDLE cycle.
                    if (!StallM) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    step_q <= '0;
                    iter_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign IFDivStartE = accept;
    assign IterEn      = iter_q;
    assign FDivDoneE   = done_q;
    assign FDivBusyE   = accept | iter_q;
    assign StepCount   = step_q;

endmodule
